// File: rtl/merge_dir_gen.sv
// Direction-bit generator for the merged CORDIC tail: one rotation decision per
// cycle using atan(2^-k) ~= 2^-k, plus the collected bit vector and final residual.
module merge_dir_gen #(
    parameter int WIDTH   = 22,
    parameter int FRAC    = 20,
    parameter int K_FIRST = 9,
    parameter int K_LAST  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [WIDTH-1:0]            z_in,
    output logic                        busy,
    output logic                        b_valid,
    output logic                        b_out,
    output logic [4:0]                  k_out,
    output logic                        done,
    output logic [K_LAST-K_FIRST:0]     b_vec,
    output logic [WIDTH-1:0]            z_res
);

    localparam int NUM = K_LAST - K_FIRST + 1;
    localparam int CW  = (NUM > 1) ? $clog2(NUM) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [WIDTH-1:0]   z_reg, z_next;
    logic               b_valid_reg, b_valid_next;
    logic               b_out_reg, b_out_next;
    logic [4:0]         k_out_reg, k_out_next;
    logic               done_reg, done_next;
    logic [NUM-1:0]     b_vec_reg, b_vec_next;
    logic [WIDTH-1:0]   z_res_reg, z_res_next;

    logic               load;
    logic               step;
    logic               b_cur;
    logic [WIDTH-1:0]   term;
    logic [WIDTH-1:0]   z_upd;
    logic [WIDTH-1:0]   term_tab [NUM];

    // Constant per-iteration step 2^(FRAC-k), indexed by cnt.
    genvar gi;
    generate
        for (gi = 0; gi < NUM; gi++) begin : g_term
            assign term_tab[gi] = WIDTH'(1) << (FRAC - K_FIRST - gi);
        end
    endgenerate

    assign term  = term_tab[cnt_reg];
    assign b_cur = ~z_reg[WIDTH-1];
    assign z_upd = b_cur ? (z_reg - term) : (z_reg + term);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        z_next       = z_reg;
        b_valid_next = 1'b0;
        b_out_next   = 1'b0;
        k_out_next   = 5'd0;
        done_next    = 1'b0;
        z_res_next   = z_res_reg;
        load         = 1'b0;
        step         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                    cnt_next   = '0;
                    z_next     = z_in;
                end
            end
            RUN: begin
                step         = 1'b1;
                z_next       = z_upd;
                b_valid_next = 1'b1;
                b_out_next   = b_cur;
                k_out_next   = 5'(K_FIRST) + 5'(cnt_reg);
                if (cnt_reg == CW'(NUM - 1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                    z_res_next = z_upd;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Each vector bit clears on a new run and captures its own iteration's decision.
    generate
        for (gi = 0; gi < NUM; gi++) begin : g_vec
            assign b_vec_next[gi] = load ? 1'b0 :
                                    (step && (cnt_reg == CW'(gi))) ? b_cur :
                                    b_vec_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            z_reg       <= '0;
            b_valid_reg <= 1'b0;
            b_out_reg   <= 1'b0;
            k_out_reg   <= 5'd0;
            done_reg    <= 1'b0;
            b_vec_reg   <= '0;
            z_res_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            z_reg       <= z_next;
            b_valid_reg <= b_valid_next;
            b_out_reg   <= b_out_next;
            k_out_reg   <= k_out_next;
            done_reg    <= done_next;
            b_vec_reg   <= b_vec_next;
            z_res_reg   <= z_res_next;
        end
    end

    assign busy    = (state_reg == RUN);
    assign b_valid = b_valid_reg;
    assign b_out   = b_out_reg;
    assign k_out   = k_out_reg;
    assign done    = done_reg;
    assign b_vec   = b_vec_reg;
    assign z_res   = z_res_reg;

endmodule
